// File: rtl/rev_alu_pkg.sv
// Shared types and sizing helpers for the reversible-gate ALU blocks.
package rev_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Plain-vector aliases of the enum for blocks that hold state as logic.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  typedef struct packed {
    logic carry;
    logic zero;
    logic parity;
    logic sign;
    logic overflow;
  } flags_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rev_full_adder.sv
// Full-adder cell built from two cascaded Peres gates; garbage lines stay internal.
module rev_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p1_q;
  logic p1_r;

  // Peres(a, b, 0) gives a^b and ab; Peres(a^b, cin, ab) gives sum and carry.
  assign p1_q = a ^ b;
  assign p1_r = a & b;
  assign s    = p1_q ^ cin;
  assign cout = (p1_q & cin) ^ p1_r;

endmodule

// File: rtl/rev_serial_addsub.sv
// Digit-serial add/subtract with valid/ready handshakes and result flags.
// Optional saturation on signed overflow is enabled by defining REV_ADDSUB_SAT_EN.
module rev_serial_addsub
  import rev_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef REV_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             parity,
  output logic             sign,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_bits(N);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  flags_t           flags_q;
`ifdef REV_ADDSUB_SAT_EN
  logic             sat_q;
`endif

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] res_final;
  logic             ovf_raw;

  // Operands shift right one digit per cycle so the cells always see the low digit.
  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    rev_full_adder u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .s   (dsum[i]),
      .cout(c[i+1])
    );
  end

  assign res_shift = (WIDTH'(dsum) << (WIDTH - DIGIT)) | (res_q >> DIGIT);
  assign ovf_raw   = c[DIGIT] ^ c[DIGIT-1];

  // On overflow the wrapped sign is the inverse of the true sign, which picks the clamp.
  always_comb begin
    res_final = res_shift;
`ifdef REV_ADDSUB_SAT_EN
    if (sat_q && ovf_raw) begin
      res_final = res_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
`ifdef REV_ADDSUB_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt     <= '0;
`ifdef REV_ADDSUB_SAT_EN
            sat_q   <= sat;
`endif
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= c[DIGIT];
          if (cnt == CW'(N - 1)) begin
            res_q   <= res_final;
            flags_q <= '{carry:    c[DIGIT],
                         zero:     (res_final == '0),
                         parity:   ^res_final,
                         sign:     res_final[WIDTH-1],
                         overflow: ovf_raw};
            state   <= ST_DONE;
          end else begin
            res_q <= res_shift;
            cnt   <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign sum       = res_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign parity    = flags_q.parity;
  assign sign      = flags_q.sign;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_rev_serial_addsub.sv
// Self-checking bench for rev_serial_addsub (WIDTH=8, DIGIT=2) against an arithmetic model.
module tb_rev_serial_addsub;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;
`ifdef REV_ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry, zero, parity, sign, overflow, busy;

  rev_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
`ifdef REV_ADDSUB_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .zero     (zero),
    .parity   (parity),
    .sign     (sign),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] sum;
    logic [4:0] flags;
    int         ready_cyc;
    bit         seen;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] last_sum;
  logic [4:0] last_flags;
  logic [7:0] m_sum;
  logic [4:0] m_flags;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags packed as {carry, zero, parity, sign, overflow}.
  function automatic void model(input logic [7:0] ai, input logic [7:0] bi,
                                input logic si, input logic sti,
                                output logic [7:0] s, output logic [4:0] f);
    int sa, sb, t;
    logic cy, ov;
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    t  = si ? (sa - sb) : (sa + sb);
    cy = si ? (ai >= bi) : ((int'(ai) + int'(bi)) > 255);
    ov = (t > 127) || (t < -128);
    s  = si ? (ai - bi) : (ai + bi);
    if (SAT_EN && sti && ov) s = (t > 0) ? 8'h7F : 8'h80;
    f = {cy, (s == 8'h00), ^s, s[7], ov};
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Scoreboard compare on every falling edge while a result is pending or shown.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sbq.size() > 0 && !sbq[0].seen && !out_valid && cyc >= sbq[0].ready_cyc) begin
          exp_t e;
          checkOutput("out_valid_late", out_valid, 1);
          e = sbq[0]; e.seen = 1'b1; sbq[0] = e;
        end
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checkOutput("spurious_out_valid", out_valid, 0);
          end else begin
            if (!sbq[0].seen) begin
              exp_t e;
              checkOutput("latency", cyc, sbq[0].ready_cyc);
              e = sbq[0]; e.seen = 1'b1; sbq[0] = e;
            end
            checkOutput("sum", sum, sbq[0].sum);
            checkOutput("flags", {carry, zero, parity, sign, overflow}, sbq[0].flags);
            checkOutput("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
              last_sum   = sum;
              last_flags = {carry, zero, parity, sign, overflow};
              void'(sbq.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi,
                               input logic si, input logic sti);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
    a = ai; b = bi; sub = si; sat = sti;
    in_valid = 1'b1;
    model(ai, bi, si, sti, e.sum, e.flags);
    e.ready_cyc = cyc + 1 + N;
    e.seen = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); sat = 1'($urandom);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_flags", {carry, zero, parity, sign, overflow}, 0);
    rst = 1'b0;

    model(8'd3, 8'd1, 1'b0, 1'b0, m_sum, m_flags);
    checkOutput("model_3p1_sum", m_sum, 8'h04);
    checkOutput("model_3p1_flags", m_flags, 5'b00100);
    model(8'd5, 8'd7, 1'b1, 1'b0, m_sum, m_flags);
    checkOutput("model_5m7_sum", m_sum, 8'hFE);
    checkOutput("model_5m7_flags", m_flags, 5'b00110);

    rdy_mode = 2;
    @(negedge clk);
    applyStimulus(8'd3, 8'd1, 1'b0, 1'b0); waitDone();
    checkOutput("dir_3p1_sum", last_sum, 8'h04);
    checkOutput("dir_3p1_flags", last_flags, 5'b00100);
    applyStimulus(8'd255, 8'd1, 1'b0, 1'b0); waitDone();
    checkOutput("dir_255p1_sum", last_sum, 8'h00);
    checkOutput("dir_255p1_flags", last_flags, 5'b11000);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0); waitDone();
    checkOutput("dir_0p0_sum", last_sum, 8'h00);
    checkOutput("dir_0p0_flags", last_flags, 5'b01000);
    applyStimulus(8'd127, 8'd127, 1'b0, 1'b1); waitDone();
    checkOutput("dir_127p127_sum", last_sum, SAT_EN ? 8'h7F : 8'hFE);
    checkOutput("dir_127p127_flags", last_flags, SAT_EN ? 5'b00101 : 5'b00111);
    applyStimulus(8'd5, 8'd7, 1'b1, 1'b0); waitDone();
    checkOutput("dir_5m7_sum", last_sum, 8'hFE);
    checkOutput("dir_5m7_flags", last_flags, 5'b00110);
    applyStimulus(8'd7, 8'd5, 1'b1, 1'b0); waitDone();
    checkOutput("dir_7m5_sum", last_sum, 8'h02);
    checkOutput("dir_7m5_flags", last_flags, 5'b10100);

    // Backpressure: hold out_ready low while offering operands that must be ignored.
    rdy_mode = 1;
    @(negedge clk);
    applyStimulus(8'd9, 8'd4, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checkOutput("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_out_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    n = 0;
    while (out_valid && n < 5) begin @(negedge clk); n++; end
    checkOutput("bp_release_in_ready", in_ready, 1);
    checkOutput("bp_sum", last_sum, 8'h05);
    waitDone();

    // Reset in the middle of a run, then confirm no stale carry leaks through.
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    sbq.delete();
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'd3, 8'd1, 1'b0, 1'b0); waitDone();
    checkOutput("postrst_sum", last_sum, 8'h04);
    checkOutput("postrst_flags", last_flags, 5'b00100);

    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    waitDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rev_serial_addsub.md
# rev_serial_addsub

Parametrised, digit-serial adder/subtractor for the reversible-gate ALU. It extends the 4-bit combinational full adder to any operand width, adds subtraction, and adds a valid/ready handshake on both sides. Each cycle it processes DIGIT bits through a chain of reversible full-adder cells, then presents the result with carry, zero, parity, sign and overflow flags. It sits between the ALU operand registers and the result/flag writeback.

## Interface
- WIDTH, 8, operand and result width; ≥2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH; N = WIDTH/DIGIT.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands offered.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a−b, computed as a+~b+1.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry out of the MSB; for sub, 1 means no borrow.
- zero  out  1  sum == 0.
- parity  out  1  XOR-reduction of sum; 1 means an odd number of ones.
- sign  out  1  sum[WIDTH-1].
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b^{WIDTH{sub}} and sub. Load the carry register with sub, clear the digit counter, go to RUN.
- RUN: each cycle, digit k (bits k·DIGIT .. k·DIGIT+DIGIT−1) passes through DIGIT chained cells. Carry-in comes from the carry register. Sum bits are written into the result register and carry-out is registered. When k reaches N−1, capture the carry into the MSB (cell DIGIT−1 input carry), compute the flags, and go to DONE.
- DONE: out_valid=1. sum and flags stay stable until out_ready=1, then go to IDLE. in_ready stays 0 throughout, so there is no overlap.
- in_valid outside IDLE is ignored. Operands are sampled only at acceptance, so later changes to a, b or sub have no effect.
- A carry out of the MSB never extends sum; it appears only on carry.
- Reset value of every output: in_ready=1, out_valid=0, busy=0, sum=0, and all flags 0.
- rst asserted in any state, including mid-RUN: the operation is abandoned, all registers clear immediately, and the result is never presented.

## Timing
- Accepting edge T. Digit k is computed at edge T+1+k.
- State DONE and out_valid=1 are reached after edge T+N, giving a latency of N cycles.
- Minimum issue interval is N+2 cycles: N for RUN, 1 for the DONE handshake edge, 1 for IDLE acceptance.
- Flags are registered together with the final digit. No output changes combinationally from inputs, except that in_ready and busy follow state only.

## Configuration
- REV_ADDSUB_SAT_EN defined:
  - Adds input sat (1 bit).
  - When sat=1 (latched at acceptance) and signed overflow occurs, sum clamps to 0111…1 if the true result is positive, or 1000…0 if negative.
  - zero, parity and sign are computed on the clamped value. carry and overflow report the unclamped arithmetic.
- Not defined: the sat port is absent and results always wrap. Latency is identical either way.

## Structure
- Package rev_alu_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the flag struct {carry, zero, parity, sign, overflow};
  - localparam helpers for N and the counter width, $clog2(N) with a minimum of 1.
- Sub-module rev_full_adder: a Peres-gate full-adder cell (a, b, cin → s, cout, with garbage outputs left unconnected). DIGIT instances are chained in a generate loop.

## Test plan
- WIDTH=4, DIGIT=1: 3+1 → sum=4, carry0 zero0 parity1 sign0 ovf0; out_valid exactly 4 cycles after acceptance.
- WIDTH=4: 15+1 → sum=0, carry1 zero1 parity0 sign0 ovf0. Then 0+0 → sum=0, zero1 carry0.
- WIDTH=4: 7+7 → sum=14, carry0 parity1 sign1 ovf1. Under REV_ADDSUB_SAT_EN with sat=1 → sum=7, sign0 parity1 ovf1.
- WIDTH=8, DIGIT=2, sub=1: 5−7 → sum=0xFE, carry0 sign1 parity1 zero0 ovf0; latency 4. Also 7−5 → sum=2, carry1.
- Backpressure: out_ready held low 5 cycles after out_valid → sum and flags stable, in_ready=0, a new in_valid is ignored. After out_ready, in_ready=1 on the next cycle.
- rst pulsed during RUN at digit 2 of 4 → out_valid=0, sum=0, in_ready=1 without waiting for a clock edge. After release, 3+1 completes correctly with no stale carry.
